// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code counter.
package gray_pkg;

  typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e;

  // All-ones mask for the low w bits (w = 32 wraps the shift to give all ones).
  function automatic logic [31:0] width_mask(int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  // Largest count value for a w-bit counter.
  function automatic logic [31:0] cnt_max(int w);
    return width_mask(w);
  endfunction

  // Binary to Gray on the low w bits.
  function automatic logic [31:0] bin2gray(logic [31:0] b, int w);
    return (b ^ (b >> 1)) & width_mask(w);
  endfunction

  // Gray to binary on the low w bits, log-step prefix XOR from the MSB.
  function automatic logic [31:0] gray2bin(logic [31:0] g, int w);
    logic [31:0] b;
    b = g & width_mask(w);
    for (int s = 1; s < 32; s = s * 2) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/gray_counter_gray_to_bin.sv
// Combinational Gray-to-binary decoder: each binary bit is the XOR of all Gray bits at or above it.
module gray_to_bin #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_c
);

  // Prefix XOR from the MSB down.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin_c[i] = ^gray_i[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_counter.sv
// Registered up/down Gray counter with clear, binary/Gray load, wrap or saturate.
module gray_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH    = 4,
  parameter bit          SATURATE = 1'b0,
  parameter int unsigned RST_VAL  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             load_gray_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] bin_o,
  output logic [WIDTH-1:0] gray_o,
  output logic             wrap_o,
  output logic             sat_o
);

  localparam cnt_mode_e        MODE     = SATURATE ? CNT_SAT : CNT_WRAP;
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(cnt_max(int'(WIDTH)));
  localparam logic [WIDTH-1:0] RST_BIN  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(32'(RST_BIN), int'(WIDTH)));

  logic [WIDTH-1:0] load_dec;
  logic [WIDTH-1:0] bin_d;
  logic [WIDTH-1:0] gray_d;
  logic             wrap_d;
  logic             sat_d;

  gray_to_bin #(.WIDTH(WIDTH)) u_load_dec (
    .gray_i (load_val_i),
    .bin_c  (load_dec)
  );

  // Next count, wrap pulse and saturate flag; clear beats load beats enable.
  always_comb begin
    bin_d  = bin_o;
    wrap_d = 1'b0;
    sat_d  = sat_o;
    if (clr_i) begin
      bin_d = RST_BIN;
      sat_d = 1'b0;
    end else if (load_i) begin
      bin_d = load_gray_i ? load_dec : load_val_i;
      sat_d = 1'b0;
    end else if (en_i) begin
      if (up_i) begin
        if (bin_o == MAX_VAL) begin
          if (MODE == CNT_SAT) begin
            sat_d = 1'b1;
          end else begin
            bin_d  = '0;
            wrap_d = 1'b1;
            sat_d  = 1'b0;
          end
        end else begin
          bin_d = bin_o + WIDTH'(1);
          sat_d = 1'b0;
        end
      end else begin
        if (bin_o == '0) begin
          if (MODE == CNT_SAT) begin
            sat_d = 1'b1;
          end else begin
            bin_d  = MAX_VAL;
            wrap_d = 1'b1;
            sat_d  = 1'b0;
          end
        end else begin
          bin_d = bin_o - WIDTH'(1);
          sat_d = 1'b0;
        end
      end
    end
    gray_d = WIDTH'(bin2gray(32'(bin_d), int'(WIDTH)));
  end

  // Output registers; Gray is encoded before the flop so it never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_o  <= RST_BIN;
      gray_o <= RST_GRAY;
      wrap_o <= 1'b0;
      sat_o  <= 1'b0;
    end else begin
      bin_o  <= bin_d;
      gray_o <= gray_d;
      wrap_o <= wrap_d;
      sat_o  <= sat_d;
    end
  end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Parametrised, fully registered Gray-code counter with up/down, synchronous clear and parallel load.
- Produces glitch-free Gray outputs, intended for FIFO read/write pointers crossing clock domains and for position encoders.
- Registers both the binary and the Gray form, so consumers never see combinational conversion logic on the outputs.
- Load value may be supplied in binary or in Gray.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..32.
- SATURATE, 0, 0 = wrap at the ends; 1 = hold at the end value.
- RST_VAL, 0, binary reset/clear value; must be < 2**WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr_i  in  1  synchronous clear to RST_VAL.
- load_i  in  1  synchronous parallel load.
- load_gray_i  in  1  1 = load_val_i is Gray-coded; 0 = binary.
- load_val_i  in  WIDTH  load value.
- en_i  in  1  count enable.
- up_i  in  1  1 = increment; 0 = decrement.
- bin_o  out  WIDTH  registered binary count.
- gray_o  out  WIDTH  registered Gray count; always equals bin_o ^ (bin_o >> 1).
- wrap_o  out  1  one-cycle pulse registered with the wrapping update.
- sat_o  out  1  high while the counter is held at an end value in saturate mode.

Behaviour:
- Reset (rst_n low, asynchronous):
  - bin_o = RST_VAL, gray_o = Gray(RST_VAL), wrap_o = 0, sat_o = 0.
  - Release is taken on the next rising edge; no counting occurs on the release edge unless en_i is high after release.
- Priority per cycle, highest first: clr_i > load_i > en_i.
- clr_i: next bin = RST_VAL; wrap_o = 0; sat_o = 0.
- load_i:
  - next bin = load_val_i if load_gray_i = 0.
  - next bin = Gray-to-binary(load_val_i) if load_gray_i = 1. The conversion is prefix XOR from the MSB: b[W-1] = g[W-1], b[i] = b[i+1] ^ g[i].
  - wrap_o = 0, sat_o = 0.
  - en_i is ignored in the load cycle.
- en_i with up_i = 1:
  - bin below 2**WIDTH-1: bin+1; wrap_o = 0; sat_o = 0.
  - bin at 2**WIDTH-1, SATURATE = 0: next = 0; wrap_o = 1 for that one cycle.
  - bin at 2**WIDTH-1, SATURATE = 1: hold; sat_o = 1; wrap_o = 0.
- en_i with up_i = 0:
  - bin above 0: bin-1; wrap_o = 0; sat_o = 0.
  - bin at 0, SATURATE = 0: next = 2**WIDTH-1; wrap_o = 1.
  - bin at 0, SATURATE = 1: hold; sat_o = 1.
- en_i low and no clr_i/load_i: hold bin; wrap_o = 0; sat_o holds its previous value.
- A direction change while saturated clears sat_o on the first move away from the end.
- Latency: the result of an input applied in cycle N appears on the outputs after edge N+1.
- gray_o is computed from next-bin and registered, never decoded from bin_o after the flop.
- Consecutive count steps change exactly one gray_o bit. Wrap steps also change exactly one bit (MSB only), because Gray code is cyclic.
- Arithmetic is modulo 2**WIDTH on WIDTH bits; no carry-out port.
- Simultaneous clr_i and load_i: clr_i wins and load_val_i is discarded.
- rst_n asserted mid-count: outputs return to reset values immediately, with no clock needed.

Decomposition:
- gray_pkg holds:
  - functions bin2gray(logic [31:0], int w) and gray2bin(logic [31:0], int w);
  - typedef enum logic {CNT_WRAP, CNT_SAT} cnt_mode_e, mapped from SATURATE;
  - localparam helper for the maximum value.
- Sub-module gray_to_bin (parameter WIDTH, purely combinational prefix-XOR) decodes load_val_i.
- The counter core stays in gray_counter.

Test Plan:
- WIDTH=4, reset then en_i=1, up_i=1 for 20 cycles: bin_o runs 0..15,0..3 and gray_o runs 0000,0001,0011,0010,...,1000,0000. wrap_o pulses once, on the 15->0 step. Every step has a Hamming distance of exactly 1.
- Load with load_gray_i=1, load_val_i=4'b1101: next cycle bin_o=9 and gray_o=1101. Then up_i=0 for 10 cycles gives 8..0,15 with wrap_o on the 0->15 step.
- SATURATE=1, load 14 binary, en_i=1, up_i=1 for 4 cycles: bin_o = 15,15,15,15, sat_o=1 from the second 15, wrap_o never asserts. Then up_i=0: bin_o=14 and sat_o=0.
- clr_i, load_i and en_i all high with RST_VAL=5 and load_val_i=12: bin_o=5, gray_o=0111, wrap_o=0.
- Assert rst_n low asynchronously between edges mid-count at bin_o=7: outputs go to RST_VAL immediately. Release, then count resumes from RST_VAL.
- Randomized 10k cycles for WIDTH=2, 7 and 16 with a scoreboard model: the assertion gray_o == bin_o ^ (bin_o>>1) holds every cycle, and gray_o has a single-bit change on every pure en_i step.
